// File: rtl/ntt_stage_scheduler.sv
// Stage/block/butterfly sequencer for the radix-2 NTT/INTT datapath.
// Issues one (p, k, i) triple per accepted cycle and drains the BFU pipeline between stages.
module ntt_stage_scheduler #(
  parameter int NUM_STAGES   = 10,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       inverse,
  input  logic       abort,
  input  logic       stall,
  output logic [3:0] p,
  output logic [7:0] k,
  output logic [7:0] i,
  output logic       addr_valid,
  output logic       busy,
  output logic       stage_done,
  output logic       done
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [3:0] P_LAST = 4'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      p_q, p_d;
  logic [7:0]      k_q, k_d;
  logic [7:0]      i_q, i_d;
  logic            inv_q, inv_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            addr_valid_q, addr_valid_d;
  logic            busy_q, busy_d;
  logic            stage_done_q, stage_done_d;
  logic            done_q, done_d;

  logic [7:0]      i_max, k_max;
  logic            last_issue, final_stage, stage_end;

  // Every stage issues 256 triples: the block size doubles as the block count halves.
  always_comb begin
    if (p_q == 4'd0) begin
      i_max = 8'd0;
      k_max = 8'd255;
    end else begin
      i_max = 8'((9'd1 << (p_q - 4'd1)) - 9'd1);
      k_max = 8'((9'd256 >> (p_q - 4'd1)) - 9'd1);
    end
    last_issue  = (k_q == k_max) && (i_q == i_max);
    final_stage = inv_q ? (p_q == 4'd0) : (p_q == P_LAST);
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    k_d          = k_q;
    i_d          = i_q;
    inv_d        = inv_q;
    drain_d      = drain_q;
    addr_valid_d = addr_valid_q;
    busy_d       = busy_q;
    stage_done_d = 1'b0;
    done_d       = 1'b0;
    stage_end    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          inv_d        = inverse;
          p_d          = inverse ? P_LAST : 4'd0;
          k_d          = 8'd0;
          i_d          = 8'd0;
          state_d      = ISSUE;
          addr_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ISSUE: begin
        // The last triple of a stage stays on p/k/i through the drain.
        if (!stall) begin
          if (last_issue) begin
            if (DRAIN_CYCLES == 0) begin
              stage_end = 1'b1;
            end else begin
              state_d      = DRAIN;
              addr_valid_d = 1'b0;
              drain_d      = '0;
            end
          end else if (i_q == i_max) begin
            i_d = 8'd0;
            k_d = k_q + 8'd1;
          end else begin
            i_d = i_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) stage_end = 1'b1;
        else drain_d = drain_q + 1'b1;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stage_end) begin
      stage_done_d = 1'b1;
      if (final_stage) begin
        state_d      = FIN;
        addr_valid_d = 1'b0;
      end else begin
        p_d          = inv_q ? (p_q - 4'd1) : (p_q + 4'd1);
        k_d          = 8'd0;
        i_d          = 8'd0;
        state_d      = ISSUE;
        addr_valid_d = 1'b1;
      end
    end

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      p_d          = 4'd0;
      k_d          = 8'd0;
      i_d          = 8'd0;
      addr_valid_d = 1'b0;
      busy_d       = 1'b0;
      stage_done_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= 4'd0;
      k_q          <= 8'd0;
      i_q          <= 8'd0;
      inv_q        <= 1'b0;
      drain_q      <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      stage_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      k_q          <= k_d;
      i_q          <= i_d;
      inv_q        <= inv_d;
      drain_q      <= drain_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      stage_done_q <= stage_done_d;
      done_q       <= done_d;
    end
  end

  assign p          = p_q;
  assign k          = k_q;
  assign i          = i_q;
  assign addr_valid = addr_valid_q;
  assign busy       = busy_q;
  assign stage_done = stage_done_q;
  assign done       = done_q;

endmodule

// File: doc/ntt_stage_scheduler.md
Name: ntt_stage_scheduler

Overview:
- Sequences the radix-2, 2-BFU NTT/INTT datapath over N=1024 coefficients, 10 stages.
- Each cycle it issues one (p, k, i) triple to the four-address generator, which turns it into four 10-bit bank addresses.
- Walks stages forward (NTT) or in reverse (INTT) and drains the butterfly pipeline between stages to avoid read-after-write hazards.
- Reports per-stage and whole-transform completion to the top-level controller.

Parameters:
- NUM_STAGES, 10: stages per transform; p spans 0..NUM_STAGES-1.
- DRAIN_CYCLES, 4: idle cycles inserted after the last issue of each stage (BFU + memory write latency); 0 is legal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- inverse  in  1  0 = NTT, stages ascend 0..9; 1 = INTT, stages descend 9..0. Latched on start.
- abort  in  1  synchronous cancel.
- stall  in  1  downstream not ready; the current triple is held.
- p  out  4  stage index to the address generator.
- k  out  8  block index.
- i  out  8  intra-block index.
- addr_valid  out  1  p/k/i valid this cycle; accepted when addr_valid && !stall.
- busy  out  1  high from the cycle after start until done.
- stage_done  out  1  one-cycle pulse when a stage has fully drained.
- done  out  1  one-cycle pulse when the transform is complete.

Behaviour:
- All outputs are registered. Reset, asynchronous: state=IDLE; p, k, i = 0; addr_valid, busy, stage_done, done = 0.
- Loop bounds are derived from the current p:
  - p=0: i_max=0, k_max=255.
  - p>=1: i_max = 2^(p-1) - 1, k_max = (256 >> (p-1)) - 1.
  - This gives 256 issues per stage for every p. Example: p=9 gives k=0 and i=0..255.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On start: latch inverse; load p = inverse ? NUM_STAGES-1 : 0; load k = 0, i = 0.
  - Go to ISSUE. busy=1 and addr_valid=1 in the next cycle, so the first issue lands in cycle 1 when start is in cycle 0.
- ISSUE:
  - addr_valid=1 throughout.
  - On acceptance, i increments. When i==i_max, i wraps to 0 and k increments.
  - The acceptance with k==k_max and i==i_max is the last issue of the stage: go to DRAIN. If DRAIN_CYCLES=0, skip DRAIN and apply the stage-end action directly.
  - While stall=1, p/k/i/addr_valid hold and nothing advances.
- DRAIN:
  - addr_valid=0. Stays for exactly DRAIN_CYCLES cycles; stall is ignored.
  - Stage-end action: pulse stage_done for one cycle.
    - If this was not the final stage, step p (+1 for NTT, -1 for INTT), clear k and i, and go to ISSUE. The stage_done cycle is the first issue cycle of the new stage.
    - If this was the final stage (p=9 for NTT, p=0 for INTT), go to FIN.
- FIN: lasts one cycle with done=1, busy=0, addr_valid=0; then IDLE. p, k, i keep their last values until the next start.
- start while busy or in FIN: ignored; no restart and no effect on the latched mode.
- abort, any non-IDLE state: next cycle returns to IDLE, clears p/k/i, drops busy and addr_valid, and emits no stage_done or done. abort has priority over start and stall.
- stall during DRAIN or IDLE: no effect.
- Reset mid-transform: immediate return to IDLE values; no pulses.
- Counter widths: k and i are 8 bits with no overflow, since bounds never exceed 255. p is 4 bits; the INTT decrement from 0 never occurs because p=0 is the final INTT stage.
- Throughput with no stall: NUM_STAGES × (256 + DRAIN_CYCLES) cycles from first issue to the final stage_done.

Test Plan:
- NTT, DRAIN_CYCLES=4, no stall, start at cycle 0:
  - addr_valid first high at cycle 1 with p=0, k=0, i=0.
  - Stage p=0 issues k=0..255 with i=0; stage p=2 issues (k,i) = (0,0),(0,1),(1,0)...(127,1); stage p=9 issues k=0, i=0..255.
  - stage_done pulses at cycles 261, 521, ..., 2601; done=1 at cycle 2602 and busy=0 from that cycle.
- INTT (inverse=1): first triple is p=9, k=0, i=0. The stage sequence is 9,8,...,0. done follows the p=0 stage with the same 2600-cycle timing.
- Stall: hold stall=1 for 3 cycles at p=1, k=5. The triple stays at p=1, k=5, i=0 with addr_valid high; the stage ends 3 cycles later; no issue is skipped or duplicated.
- Boundary and DRAIN_CYCLES=0: the last p=3 issue (k=31, i=3) is followed next cycle by p=4, k=0, i=0 with stage_done=1, with no addr_valid gap.
- Abort at p=5 mid-stage: next cycle busy=0, addr_valid=0, p=k=i=0, no done. A subsequent start restarts at p=0.
- Async reset asserted during DRAIN: outputs go to 0 immediately without waiting for a clock edge. start pulsed during busy at cycle 100 has no effect on the sequence.
